call_return_ctrl: RTL
=====================

// Module: call_return_ctrl
// PURPOSE
//  Program-counter sequencer that owns the 16-entry return-address stack in the jump_cmd datapath.
//  Accepts one flow command per cycle: NEXT, JMP, CALL or RET.
//  Drives stack push/pop/data and the stack's reset, and tracks depth to flag overflow/underflow,
//  which the stack itself silently wraps.
//  Sits between the instruction decoder (cmd_*) and the stack; pc feeds the instruction fetch.
// PARAMETERS
//  AW        11   address / PC width; equals the stack data width
//  DEPTH     16   stack entries; legal depth range 0..DEPTH
//  RESET_PC  0    PC value after reset
// PORTS
//  clk        in   1    single clock, rising edge
//  reset      in   1    synchronous, active-high
//  start      in   1    pulse: load pc<=start_addr, clear depth/fault, enter RUN
//  start_addr in   AW   PC loaded by start
//  cmd_valid  in   1    command present this cycle
//  cmd_ready  out  1    controller accepts command (transfer = valid & ready)
//  cmd        in   2    00 NEXT, 01 JMP, 10 CALL, 11 RET
//  target     in   AW   destination for JMP/CALL
//  pc         out  AW   current program counter (registered)
//  stk_push   out  1    to stack push (combinational, one cycle per accepted CALL)
//  stk_pop    out  1    to stack pop (combinational, one cycle per accepted RET)
//  stk_reset  out  1    to stack reset = reset | start
//  stk_din    out  AW   to stack_in = pc+1 (mod 2^AW)
//  stk_dout   in   AW   from stack_out (top of stack, combinational)
//  depth      out  clog2(DEPTH+1)  live entries
//  fault      out  1    sticky: overflow or underflow occurred
//  fault_ovf  out  1    sticky: CALL refused at depth==DEPTH
//  fault_udf  out  1    sticky: RET refused at depth==0
// BEHAVIOUR
//  - States: IDLE, RUN, FAULT. Reset -> IDLE, pc=RESET_PC, depth=0, all faults=0.
//    During reset cycle stk_reset=1, push/pop=0.
//  - cmd_ready=1 only in RUN. In IDLE/FAULT commands are ignored; push/pop stay 0.
//  - start (any state) has priority over everything, cmd ignored that cycle.
//    Next cycle: RUN, pc=start_addr, depth=0, faults cleared.
//  - Accepted commands (RUN), pc updates on next edge, i.e. 1-cycle latency:
//    NEXT: pc<=pc+1 (wraps 2^AW-1 -> 0).
//    JMP:  pc<=target.
//    CALL: depth<DEPTH -> stk_push=1, stk_din=pc+1, pc<=target, depth+1.
//          depth==DEPTH -> no push, pc holds, fault_ovf=fault=1, ->FAULT.
//    RET:  depth>0 -> stk_pop=1, pc<=stk_dout (sampled same cycle, before pop takes effect), depth-1.
//          depth==0 -> no pop, pc holds, fault_udf=fault=1, ->FAULT.
//  - cmd_valid=0 in RUN: pc holds, no stack activity.
//  - stk_push and stk_pop are never both 1. Neither is asserted in the same cycle as stk_reset.
//  - FAULT is left only by start or reset. pc and depth freeze in FAULT.
//  - CALL pushing pc=2^AW-1 stores 0 (wrap of pc+1).
//  - Reset mid-operation: a cmd in the reset cycle is dropped. Stack pointer is re-synced via stk_reset.
// TESTING (bench instantiates this block with the real stack module)
//  1 reset, start addr=0x010, 3xNEXT -> pc 0x010,0x011,0x012,0x013; cmd_ready=1 from cycle after start.
//  2 CALL 0x100 at pc=0x020, NEXT, RET -> push of 0x021; pc 0x100,0x101,0x021; depth 1 then 0.
//  3 16 nested CALLs then 17th CALL -> depth=16, fault_ovf=1, pc holds, no push, cmd_ready=0.
//    Then start 0x000 -> fault cleared.
//  4 RET at depth 0 after start -> fault_udf=1, no pop, pc unchanged, state FAULT.
//  5 start asserted together with CALL valid -> CALL dropped, no push, pc=start_addr, depth=0.
//  6 CALL at pc=0x7FF -> pushed 0x000; later RET -> pc=0x000.
//    Reset during a RET cycle -> no pop, pc=RESET_PC.

Source files
------------

// File: rtl/call_return_ctrl.sv
// Program-counter sequencer for the jump_cmd datapath: steps, jumps, calls and returns
// through an external return-address stack while tracking its depth to flag over/underflow.
module call_return_ctrl #(
    parameter int              AW       = 11,
    parameter int              DEPTH    = 16,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter int              DW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd,
    input  logic [AW-1:0] target,
    output logic [AW-1:0] pc,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_reset,
    output logic [AW-1:0] stk_din,
    input  logic [AW-1:0] stk_dout,
    output logic [DW-1:0] depth,
    output logic          fault,
    output logic          fault_ovf,
    output logic          fault_udf,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [1:0] CMD_NEXT = 2'b00;
    localparam logic [1:0] CMD_JMP  = 2'b01;
    localparam logic [1:0] CMD_CALL = 2'b10;
    localparam logic [1:0] CMD_RET  = 2'b11;

    state_t state;
    logic   accept;
    logic   full;
    logic   empty;

    // Handshake: a command transfers on a cycle where cmd_valid & cmd_ready are both high.
    // cmd_ready drops during reset/start so a command presented then is never counted as taken.
    assign cmd_ready = (state == ST_RUN) && !start && !reset;
    assign accept    = cmd_valid && cmd_ready;
    assign full      = (depth == DW'(DEPTH));
    assign empty     = (depth == '0);

    assign stk_push  = accept && (cmd == CMD_CALL) && !full;
    assign stk_pop   = accept && (cmd == CMD_RET) && !empty;
    assign stk_reset = reset || start;
    assign stk_din   = pc + AW'(1);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            depth     <= '0;
            fault     <= 1'b0;
            fault_ovf <= 1'b0;
            fault_udf <= 1'b0;
        end else if (start) begin
            state     <= ST_RUN;
            pc        <= start_addr;
            depth     <= '0;
            fault     <= 1'b0;
            fault_ovf <= 1'b0;
            fault_udf <= 1'b0;
        end else if (accept) begin
            case (cmd)
                CMD_NEXT: pc <= pc + AW'(1);
                CMD_JMP:  pc <= target;
                CMD_CALL: begin
                    if (full) begin
                        fault     <= 1'b1;
                        fault_ovf <= 1'b1;
                        state     <= ST_FAULT;
                    end else begin
                        pc    <= target;
                        depth <= depth + DW'(1);
                    end
                end
                CMD_RET: begin
                    // Top of stack is read in the same cycle the pop is issued.
                    if (empty) begin
                        fault     <= 1'b1;
                        fault_udf <= 1'b1;
                        state     <= ST_FAULT;
                    end else begin
                        pc    <= stk_dout;
                        depth <= depth - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
